// File: rtl/automata_pkg.sv
// Shared types for the cellular-automaton row datapath.
// Boundary modes, window-buffer states and halo side select.
package automata_pkg;

  typedef enum logic [1:0] {
    BND_ZERO    = 2'd0,
    BND_ONE     = 2'd1,
    BND_REFLECT = 2'd2
  } boundary_mode_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    PEND  = 2'd1,
    DRAIN = 2'd2
  } wbuf_state_t;

  typedef enum logic {
    SIDE_LEFT  = 1'b0,
    SIDE_RIGHT = 1'b1
  } halo_side_t;

endpackage

// File: rtl/automaton_halo_fill.sv
// Combinational row-edge halo generator.
// Produces HALO fill cells for the left or right edge of a row.
module automaton_halo_fill
  import automata_pkg::*;
#(
  parameter int CHUNK_W = 20,
  parameter int HALO    = 1
) (
  input  logic [1:0]         mode,
  input  logic [CHUNK_W-1:0] chunk,
  input  logic               side,
  output logic [HALO-1:0]    halo
);

  logic [HALO-1:0] w_refl;

  // Mirror about the row edge: the cell nearest the edge lands next to it.
  always_comb begin
    w_refl = '0;
    for (int j = 0; j < HALO; j++) begin
      if (side == SIDE_RIGHT) begin
        w_refl[j] = chunk[HALO-1-j];
      end else begin
        w_refl[j] = chunk[CHUNK_W-1-j];
      end
    end
  end

  always_comb begin
    halo = '0;
    unique case (1'b1)
      (mode == BND_ONE):     halo = '1;
      (mode == BND_REFLECT): halo = w_refl;
      default:               halo = '0;
    endcase
  end

endmodule

// File: rtl/automaton_window_buffer.sv
// Row-window buffer: chunk stream in, haloed windows out.
// One chunk is held back so its right halo can come from the next chunk.
module automaton_window_buffer
  import automata_pkg::*;
#(
  parameter int CHUNK_W = 20,
  parameter int HALO    = 1,
  parameter int IDX_W   = 6
) (
  input  logic                      clk,
  input  logic                      clear_n,
  input  logic [1:0]                mode,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHUNK_W-1:0]        in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHUNK_W+2*HALO-1:0] out_window,
  output logic                      out_last,
  output logic [IDX_W-1:0]          out_index
);

  localparam int WIN_W = CHUNK_W + 2 * HALO;

  wbuf_state_t r_state;
  wbuf_state_t w_state_nxt;

  logic [CHUNK_W-1:0] r_cur;
  logic [HALO-1:0]    r_lh;
  logic [1:0]         r_mode;
  logic [IDX_W-1:0]   r_idx;
  logic               r_out_valid;
  logic [WIN_W-1:0]   r_out_window;
  logic               r_out_last;
  logic [IDX_W-1:0]   r_out_index;

  logic            w_free;
  logic            w_first;
  logic            w_emit;
  logic            w_fin;
  logic            w_in_ready;
  logic [HALO-1:0] w_lfill;
  logic [HALO-1:0] w_rfill;

  automaton_halo_fill #(
    .CHUNK_W(CHUNK_W),
    .HALO   (HALO)
  ) u_lfill (
    .mode (mode),
    .chunk(in_data),
    .side (SIDE_LEFT),
    .halo (w_lfill)
  );

  automaton_halo_fill #(
    .CHUNK_W(CHUNK_W),
    .HALO   (HALO)
  ) u_rfill (
    .mode (r_mode),
    .chunk(r_cur),
    .side (SIDE_RIGHT),
    .halo (w_rfill)
  );

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_free      = !r_out_valid || out_ready;
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_first     = 1'b0;
    w_emit      = 1'b0;
    w_fin       = 1'b0;
    unique case (r_state)
      EMPTY: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_first     = 1'b1;
          w_state_nxt = in_last ? DRAIN : PEND;
        end
      end
      PEND: begin
        w_in_ready = w_free;
        if (in_valid && w_free) begin
          w_emit = 1'b1;
          if (in_last) begin
            w_state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (w_free) begin
          w_fin       = 1'b1;
          w_state_nxt = EMPTY;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_cur        <= '0;
      r_lh         <= '0;
      r_mode       <= '0;
      r_idx        <= '0;
      r_out_valid  <= 1'b0;
      r_out_window <= '0;
      r_out_last   <= 1'b0;
      r_out_index  <= '0;
    end else begin
      if (w_free) begin
        r_out_valid <= 1'b0;
      end
      if (w_first) begin
        r_cur  <= in_data;
        r_lh   <= w_lfill;
        r_mode <= mode;
        r_idx  <= '0;
      end
      if (w_emit) begin
        r_out_window <= {r_lh, r_cur, in_data[CHUNK_W-1 -: HALO]};
        r_out_last   <= 1'b0;
        r_out_index  <= r_idx;
        r_out_valid  <= 1'b1;
        r_lh         <= r_cur[HALO-1:0];
        r_cur        <= in_data;
        r_idx        <= r_idx + IDX_W'(1);
      end
      if (w_fin) begin
        r_out_window <= {r_lh, r_cur, w_rfill};
        r_out_last   <= 1'b1;
        r_out_index  <= r_idx;
        r_out_valid  <= 1'b1;
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign out_window = r_out_window;
  assign out_last   = r_out_last;
  assign out_index  = r_out_index;

endmodule

// File: tb/tb_automaton_window_buffer.sv
// Bench for automaton_window_buffer: row-level reference model,
// directed literal scenarios and randomized rows with backpressure.
module tb_automaton_window_buffer;

  localparam int W   = 20;
  localparam int H   = 1;
  localparam int IX  = 6;
  localparam int WIN = W + 2 * H;

  typedef struct {
    logic [WIN-1:0] w;
    logic           l;
    logic [IX-1:0]  idx;
  } win_t;

  logic           clk;
  logic           clear_n;
  logic [1:0]     mode;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
  logic           in_last;
  logic           out_valid;
  logic           out_ready;
  logic [WIN-1:0] out_window;
  logic           out_last;
  logic [IX-1:0]  out_index;

  automaton_window_buffer #(
    .CHUNK_W(W),
    .HALO   (H),
    .IDX_W  (IX)
  ) dut (
    .clk       (clk),
    .clear_n   (clear_n),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_window(out_window),
    .out_last  (out_last),
    .out_index (out_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit rand_rdy = 0;

  win_t exp_q[$];
  win_t got[$];
  bit   row_cells[$];
  int   row_mode;
  bit   row_act = 0;
  int   row_k;

  logic [WIN-1:0] p_win;
  logic           p_last;
  logic [IX-1:0]  p_idx;
  bit             p_hold = 0;

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, a, e, $time);
    end
  endtask

  // Cell i of the current row, with boundary extension.
  function automatic bit cellv(input int i);
    int n;
    n = row_cells.size();
    if (i >= 0 && i < n) return row_cells[i];
    case (row_mode)
      1: return 1'b1;
      2: return (i < 0) ? row_cells[-1 - i] : row_cells[2 * n - 1 - i];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [WIN-1:0] mkwin(input int k);
    logic [WIN-1:0] w;
    w = '0;
    for (int c = 0; c < WIN; c++) w[WIN-1-c] = cellv(k * W - H + c);
    return w;
  endfunction

  task automatic model_accept();
    int   nch;
    win_t e;
    if (!row_act) begin
      row_act = 1;
      row_cells.delete();
      row_k = 0;
      row_mode = int'(mode);
    end
    for (int b = W - 1; b >= 0; b--) row_cells.push_back(in_data[b]);
    nch = row_cells.size() / W;
    if (in_last) begin
      while (row_k < nch) begin
        e.w = mkwin(row_k);
        e.l = (row_k == nch - 1);
        e.idx = IX'(row_k);
        exp_q.push_back(e);
        row_k++;
      end
      row_act = 0;
    end else begin
      while (row_k < nch - 1) begin
        e.w = mkwin(row_k);
        e.l = 1'b0;
        e.idx = IX'(row_k);
        exp_q.push_back(e);
        row_k++;
      end
    end
  endtask

  always @(negedge clk) begin
    win_t e;
    win_t a;
    if (!clear_n) begin
      exp_q.delete();
      row_cells.delete();
      row_act = 0;
      p_hold = 0;
    end else begin
      if (p_hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_window", out_window, p_win);
        chk("hold_last", out_last, p_last);
        chk("hold_index", out_index, p_idx);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_window", out_valid, 0);
        end else begin
          e = exp_q[0];
          chk("win", out_window, e.w);
          chk("last", out_last, e.l);
          chk("index", out_index, e.idx);
          if (out_ready) void'(exp_q.pop_front());
        end
        if (out_ready) begin
          a.w = out_window;
          a.l = out_last;
          a.idx = out_index;
          got.push_back(a);
        end
      end
      p_hold = out_valid && !out_ready;
      p_win = out_window;
      p_last = out_last;
      p_idx = out_index;
      if (in_valid && in_ready) model_accept();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [W-1:0] d, input logic l,
                      input logic [1:0] m);
    int n;
    bit done;
    n = 0;
    done = 0;
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    mode = m;
    while (!done) begin
      @(negedge clk);
      done = in_ready;
      n++;
      tick();
      if (!done && n > 200) begin
        total++;
        bad++;
        $display("FAIL accept_timeout got=0 want=1 t=%0t", $time);
        done = 1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      tick();
      n++;
    end
    chk("drain_in_time", (n < 500), 1);
  endtask

  task automatic wait_got(input int cnt);
    int n;
    n = 0;
    while (got.size() < cnt && n < 100) begin
      tick();
      n++;
    end
    chk("window_count", got.size(), cnt);
  endtask

  initial begin
    int idle;
    int len;
    logic [1:0] m;
    logic [W-1:0] sd [6];
    logic         sl [6];
    logic [1:0]   sm [6];

    clear_n = 1'b0;
    mode = 2'd0;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_window", out_window, 0);
    chk("rst_last", out_last, 0);
    chk("rst_index", out_index, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    clear_n = 1'b1;
    tick();

    // Zero mode, 3-chunk row
    got.delete();
    send(20'h80001, 1'b0, 2'd0);
    send(20'h00003, 1'b0, 2'd0);
    send(20'hC0000, 1'b1, 2'd0);
    wait_got(3);
    if (got.size() >= 3) begin
      chk("z3_w0", got[0].w, 22'h100002);
      chk("z3_w1", got[1].w, 22'h200007);
      chk("z3_w2", got[2].w, 22'h380000);
      chk("z3_l0", got[0].l, 0);
      chk("z3_l2", got[2].l, 1);
      chk("z3_i1", got[1].idx, 1);
      chk("z3_i2", got[2].idx, 2);
    end
    wait_idle();

    // Reflect mode, single chunk: window two cycles after accept
    send(20'h80001, 1'b1, 2'd2);
    @(negedge clk);
    chk("refl_lat1_valid", out_valid, 0);
    tick();
    @(negedge clk);
    chk("refl_lat2_valid", out_valid, 1);
    chk("refl_win", out_window, 22'h300003);
    chk("refl_last", out_last, 1);
    wait_idle();

    // Ones mode, single chunk
    got.delete();
    send(20'h00000, 1'b1, 2'd1);
    wait_got(1);
    if (got.size() >= 1) chk("ones_win", got[0].w, 22'h200001);
    wait_idle();

    // Backpressure
    send(20'h12345, 1'b0, 2'd0);
    send(20'hABCDE, 1'b0, 2'd0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 20'h0F0F0;
    in_last = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_win", out_window, 22'h02468B);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_accept", in_ready, 1);
    tick();
    in_valid = 1'b0;
    send(20'h55555, 1'b1, 2'd0);
    wait_idle();

    // Back-to-back rows; mid-row mode changes are ignored
    sd[0] = 20'h80001; sl[0] = 0; sm[0] = 2'd2;
    sd[1] = 20'h00003; sl[1] = 0; sm[1] = 2'd1;
    sd[2] = 20'hC0000; sl[2] = 1; sm[2] = 2'd1;
    sd[3] = 20'h00000; sl[3] = 0; sm[3] = 2'd1;
    sd[4] = 20'h00001; sl[4] = 1; sm[4] = 2'd0;
    sd[5] = 20'h00000; sl[5] = 0; sm[5] = 2'd0;
    got.delete();
    idle = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data = sd[i];
      in_last = sl[i];
      mode = sm[i];
      @(negedge clk);
      while (!in_ready && idle < 20) begin
        idle++;
        tick();
        @(negedge clk);
      end
      tick();
    end
    in_valid = 1'b0;
    chk("b2b_idle_cycles", idle, 1);
    wait_got(5);
    if (got.size() >= 5) begin
      chk("b2b_r1_w0", got[0].w, 22'h300002);
      chk("b2b_r1_w2", got[2].w, 22'h380000);
      chk("b2b_r2_w0", got[3].w, 22'h200000);
      chk("b2b_r2_w1", got[4].w, 22'h000003);
    end
    wait_idle();

    // Reset mid-row
    send(20'h13579, 1'b0, 2'd0);
    send(20'h2468A, 1'b0, 2'd0);
    clear_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_window", out_window, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_index", out_index, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    tick();
    clear_n = 1'b1;
    got.delete();
    send(20'h80000, 1'b0, 2'd1);
    send(20'h00001, 1'b1, 2'd1);
    wait_got(2);
    if (got.size() >= 1) begin
      chk("post_rst_w0", got[0].w, 22'h300000);
      chk("post_rst_i0", got[0].idx, 0);
    end
    wait_idle();

    // Randomized rows with random gaps and backpressure
    rand_rdy = 1;
    for (int r = 0; r < 40; r++) begin
      len = (r == 7) ? 70 : int'($urandom_range(1, 5));
      m = 2'($urandom_range(0, 3));
      for (int c = 0; c < len; c++) begin
        while ($urandom_range(0, 3) == 0) tick();
        send(W'($urandom), (c == len - 1), (c == 0) ? m : 2'($urandom));
      end
    end
    rand_rdy = 0;
    out_ready = 1'b1;
    wait_idle();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
